// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: load-use stall and operand forwarding control for a 5-stage pipeline
//   Clk, Reset            : clock, synchronous active-high reset
//   ID_VALID              : IF/ID holds a real instruction
//   ID_RS/ID_RT           : source registers of the instruction in ID
//   ID_USES_RS/ID_USES_RT : the instruction actually reads that source
//   ID_DEST/ID_RF_ENABLE  : destination and register-file write enable of the ID instruction
//   ID_LOAD_INSTR         : the ID instruction is a load
//   PC_LE/IF_ID_LE        : front-end load enables, low during a load-use stall
//   ID_EX_NOP             : inject a bubble into ID/EX
//   MX1_SEL/MX2_SEL       : operand source, 00 reg file, 01 EX, 10 MEM, 11 WB
//   STALL_COUNT           : saturating count of load-use stall cycles
module hazard_forward_unit #(
   parameter int CNT_W = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             ID_VALID,
   input  logic [4:0]       ID_RS,
   input  logic [4:0]       ID_RT,
   input  logic             ID_USES_RS,
   input  logic             ID_USES_RT,
   input  logic [4:0]       ID_DEST,
   input  logic             ID_RF_ENABLE,
   input  logic             ID_LOAD_INSTR,
   output logic             PC_LE,
   output logic             IF_ID_LE,
   output logic             ID_EX_NOP,
   output logic [1:0]       MX1_SEL,
   output logic [1:0]       MX2_SEL,
   output logic [CNT_W-1:0] STALL_COUNT
);
   // Only the EX tag needs the load bit: a load further down already has its data.
   logic             ex_v_q, ex_v_d, ex_ld_q, ex_ld_d;
   logic [4:0]       ex_dst_q, ex_dst_d;
   logic             mem_v_q, mem_v_d;
   logic [4:0]       mem_dst_q, mem_dst_d;
   logic             wb_v_q, wb_v_d;
   logic [4:0]       wb_dst_q, wb_dst_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             live, stall;
   logic             ex_rs, ex_rt, mem_rs, mem_rt, wb_rs, wb_rt;

   function automatic logic hit(input logic v, input logic [4:0] d, input logic [4:0] r);
      return v && (d == r) && (r != 5'd0);
   endfunction

   // Youngest producer wins; an EX load yields 00 because the stall covers it.
   function automatic logic [1:0] fwd(input logic use_src, input logic ld, input logic e,
                                      input logic m, input logic w);
      return !use_src ? 2'b00 : e ? (ld ? 2'b00 : 2'b01) : m ? 2'b10 : w ? 2'b11 : 2'b00;
   endfunction

   always_comb begin
      live        = ID_VALID & ~Reset;
      ex_rs       = hit(ex_v_q, ex_dst_q, ID_RS);
      ex_rt       = hit(ex_v_q, ex_dst_q, ID_RT);
      mem_rs      = hit(mem_v_q, mem_dst_q, ID_RS);
      mem_rt      = hit(mem_v_q, mem_dst_q, ID_RT);
      wb_rs       = hit(wb_v_q, wb_dst_q, ID_RS);
      wb_rt       = hit(wb_v_q, wb_dst_q, ID_RT);
      stall       = live & ex_ld_q & ((ID_USES_RS & ex_rs) | (ID_USES_RT & ex_rt));
      PC_LE       = ~stall;
      IF_ID_LE    = ~stall;
      ID_EX_NOP   = stall;
      MX1_SEL     = fwd(live & ID_USES_RS, ex_ld_q, ex_rs, mem_rs, wb_rs);
      MX2_SEL     = fwd(live & ID_USES_RT, ex_ld_q, ex_rt, mem_rt, wb_rt);
      ex_v_d      = ~stall & ID_VALID & ID_RF_ENABLE & (ID_DEST != 5'd0);
      ex_dst_d    = ID_DEST;
      ex_ld_d     = ID_LOAD_INSTR;
      mem_v_d     = ex_v_q;
      mem_dst_d   = ex_dst_q;
      wb_v_d      = mem_v_q;
      wb_dst_d    = mem_dst_q;
      cnt_d       = (stall && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
      STALL_COUNT = cnt_q;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         ex_v_q  <= 1'b0;
         mem_v_q <= 1'b0;
         wb_v_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         ex_v_q  <= ex_v_d;
         mem_v_q <= mem_v_d;
         wb_v_q  <= wb_v_d;
         cnt_q   <= cnt_d;
      end
      ex_dst_q  <= ex_dst_d;
      ex_ld_q   <= ex_ld_d;
      mem_dst_q <= mem_dst_d;
      wb_dst_q  <= wb_dst_d;
   end
endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb_hazard_forward_unit: directed checks of stalls, forwarding priority and the stall counter
module tb_hazard_forward_unit;
   logic        clk = 1'b0, rst = 1'b1;
   logic        v = 1'b0, urs = 1'b0, urt = 1'b0, rf = 1'b0, ld = 1'b0;
   logic [4:0]  rs = '0, rt = '0, dst = '0;
   logic        pc_le, ifid_le, nop;
   logic [1:0]  mx1, mx2;
   logic [15:0] cnt;
   logic        s_pc, s_ifid, s_nop;
   logic [1:0]  s_mx1, s_mx2;
   logic [1:0]  s_cnt;
   int          n_assert = 0, n_fail = 0;

   always #5 clk = ~clk;

   hazard_forward_unit dut (
      .Clk(clk), .Reset(rst), .ID_VALID(v), .ID_RS(rs), .ID_RT(rt),
      .ID_USES_RS(urs), .ID_USES_RT(urt), .ID_DEST(dst), .ID_RF_ENABLE(rf),
      .ID_LOAD_INSTR(ld), .PC_LE(pc_le), .IF_ID_LE(ifid_le), .ID_EX_NOP(nop),
      .MX1_SEL(mx1), .MX2_SEL(mx2), .STALL_COUNT(cnt)
   );

   hazard_forward_unit #(.CNT_W(2)) dut_s (
      .Clk(clk), .Reset(rst), .ID_VALID(v), .ID_RS(rs), .ID_RT(rt),
      .ID_USES_RS(urs), .ID_USES_RT(urt), .ID_DEST(dst), .ID_RF_ENABLE(rf),
      .ID_LOAD_INSTR(ld), .PC_LE(s_pc), .IF_ID_LE(s_ifid), .ID_EX_NOP(s_nop),
      .MX1_SEL(s_mx1), .MX2_SEL(s_mx2), .STALL_COUNT(s_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic set(input logic iv, input logic [4:0] irs, input logic [4:0] irt, input logic iurs,
                      input logic iurt, input logic [4:0] idst, input logic irf, input logic ild);
      v = iv; rs = irs; rt = irt; urs = iurs; urt = iurt; dst = idst; rf = irf; ld = ild;
      #1;
   endtask

   task automatic bubble();   set(0, 0, 0, 0, 0, 0, 0, 0); endtask
   task automatic alu(input logic [4:0] d); set(1, 0, 0, 0, 0, d, 1, 0); endtask
   task automatic lw(input logic [4:0] d);  set(1, 0, 0, 0, 0, d, 1, 1); endtask
   task automatic rd(input logic [4:0] a, input logic [4:0] b, input logic ua, input logic ub);
      set(1, a, b, ua, ub, 5'd20, 0, 0);
   endtask

   task automatic flush();
      bubble();
      repeat (3) adv();
   endtask

   task automatic chk_pass(input string tag);
      chk({tag, "_pc"}, pc_le, 1);
      chk({tag, "_ifid"}, ifid_le, 1);
      chk({tag, "_nop"}, nop, 0);
   endtask

   initial begin
      repeat (2) adv();
      rst = 1'b0;
      bubble();
      for (int i = 0; i < 3; i++) begin
         chk_pass("idle");
         chk("idle_mx1", mx1, 0);
         chk("idle_mx2", mx2, 0);
         chk("idle_cnt", cnt, 0);
         adv();
      end
      // producer distance 1..4 for operand A
      for (int gap = 0; gap < 4; gap++) begin
         alu(5);
         adv();
         for (int k = 0; k < gap; k++) begin
            alu(7);
            adv();
         end
         rd(5, 0, 1, 0);
         chk($sformatf("dist%0d_mx1", gap + 1), mx1, gap == 0 ? 1 : gap == 1 ? 2 : gap == 2 ? 3 : 0);
         chk($sformatf("dist%0d_nop", gap + 1), nop, 0);
         adv();
         flush();
      end
      // load-use on operand B
      lw(8);
      adv();
      rd(0, 8, 0, 1);
      chk("lu_pc", pc_le, 0);
      chk("lu_ifid", ifid_le, 0);
      chk("lu_nop", nop, 1);
      chk("lu_mx2", mx2, 0);
      adv();
      chk_pass("lu2");
      chk("lu2_mx2", mx2, 2);
      chk("lu_cnt", cnt, 1);
      adv();
      flush();
      // register zero never forwards or stalls
      alu(0);
      adv();
      rd(0, 0, 1, 1);
      chk("r0_mx1", mx1, 0);
      chk_pass("r0");
      adv();
      lw(0);
      adv();
      rd(0, 0, 1, 1);
      chk_pass("lw0");
      chk("lw0_mx2", mx2, 0);
      adv();
      flush();
      // youngest producer wins over an older one in MEM
      alu(3);
      adv();
      alu(3);
      adv();
      rd(3, 3, 1, 1);
      chk("yw_mx1", mx1, 1);
      chk("yw_mx2", mx2, 1);
      adv();
      // unused source never forwards
      alu(4);
      adv();
      rd(4, 4, 0, 0);
      chk("unused_mx1", mx1, 0);
      chk("unused_mx2", mx2, 0);
      adv();
      flush();
      chk("cnt_keep", cnt, 1);
      // saturation of the 2-bit counter
      rst = 1'b1;
      adv();
      rst = 1'b0;
      chk("rst_scnt", s_cnt, 0);
      for (int p = 0; p < 5; p++) begin
         lw(8);
         adv();
         rd(0, 8, 0, 1);
         chk($sformatf("sat%0d_nop", p), s_nop, 1);
         adv();
         chk($sformatf("sat%0d_cnt", p), s_cnt, p == 0 ? 1 : p == 1 ? 2 : 3);
         chk($sformatf("sat%0d_mx2", p), s_mx2, 2);
         adv();
      end
      chk("big_cnt5", cnt, 5);
      // reset in the middle of a stall
      lw(8);
      adv();
      rd(0, 8, 0, 1);
      chk("mid_nop", nop, 1);
      rst = 1'b1;
      #1;
      chk_pass("mid_rst");
      chk("mid_rst_mx2", mx2, 0);
      adv();
      chk("mid_cnt", cnt, 0);
      chk("mid_scnt", s_cnt, 0);
      rst = 1'b0;
      #1;
      chk_pass("post_rst");
      chk("post_rst_mx2", mx2, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/hazard_forward_unit.md
# hazard_forward_unit

Backward-control companion to the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It keeps its own shadow pipeline of destination-register tags for EX, MEM and WB. From these tags and the operands of the instruction in ID it drives three things:

- forwarding selects for the MX1/MX2 operand muxes,
- load enables for the PC and IF/ID register,
- a bubble request that zeroes the ID/EX control fields.

It also counts load-use stall cycles for performance monitoring.

## Interface
Parameters:
- CNT_W, 16, width of the saturating stall counter

Ports:
- Clk  in  1  clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high; clears all state
- ID_VALID  in  1  IF/ID holds a real instruction (0 = bubble)
- ID_RS  in  5  source A register (instr[25:21])
- ID_RT  in  5  source B register (instr[20:16])
- ID_USES_RS  in  1  instruction in ID reads RS
- ID_USES_RT  in  1  instruction in ID reads RT
- ID_DEST  in  5  destination register selected in ID (rd/rt/31)
- ID_RF_ENABLE  in  1  instruction in ID writes the register file
- ID_LOAD_INSTR  in  1  instruction in ID is a load
- PC_LE  out  1  PC load enable
- IF_ID_LE  out  1  IF/ID load enable
- ID_EX_NOP  out  1  ID/EX captures zeroed control signals this edge
- MX1_SEL  out  2  operand A source: 00 reg file, 01 EX ALU result, 10 MEM result (mem-to-reg mux), 11 WB write data
- MX2_SEL  out  2  operand B source, same encoding
- STALL_COUNT  out  CNT_W  number of load-use stall cycles, saturating

## Operation
Shadow tag state: one entry per stage, each holding {valid, dest[4:0], load}.

Tag capture into EX (t_ex), every edge:
- If `stall` = 1: valid is written 0 (bubble).
- Otherwise: valid = ID_VALID & ID_RF_ENABLE & (ID_DEST != 0), with dest = ID_DEST and load = ID_LOAD_INSTR.

Tag pipeline advance, every edge with Reset = 0: t_wb ← t_mem, then t_mem ← t_ex. Tags never freeze; the downstream stages always advance.

A stage "matches" source r when its entry is valid, its dest == r, and r != 0. Register 0 never matches and never forwards.

Stall:
- `stall` = ID_VALID & t_ex.load & t_ex matches a used source. A used source is ID_RS when ID_USES_RS = 1, or ID_RT when ID_USES_RT = 1.
- When stall = 1: PC_LE = 0, IF_ID_LE = 0, ID_EX_NOP = 1.
- When stall = 0: PC_LE = 1, IF_ID_LE = 1, ID_EX_NOP = 0.

Forward select, evaluated per source:
- Priority is EX > MEM > WB (youngest producer wins).
- The first matching stage gives 01, 10 or 11; no match gives 00.
- A match in EX on a load sets that select to 00; the stall covers it.
- Selects are 00 whenever ID_VALID = 0 or the corresponding USES bit = 0.

STALL_COUNT: increments by 1 on each edge where stall = 1, and holds at all ones once reached.

Reset:
- Edge with Reset = 1: all tag valids become 0 and STALL_COUNT becomes 0.
- While Reset = 1, outputs are forced combinationally to PC_LE = 1, IF_ID_LE = 1, ID_EX_NOP = 0, MX1_SEL = MX2_SEL = 00.
- Reset asserted mid-stall drops the stall immediately; pending tags are discarded.

## Timing
- PC_LE, IF_ID_LE, ID_EX_NOP, MX1_SEL and MX2_SEL are combinational from the ID inputs and registered tags. They are valid in the same cycle the instruction sits in ID. There is no registered latency.
- Tag state and STALL_COUNT are registered, one-edge latency.
- A load-use hazard costs exactly one stall cycle:
  - Cycle n: stall = 1 and the bubble enters t_ex.
  - Cycle n+1: the load is in t_mem and the same ID instruction sees select 10.
- Back-to-back dependent loads stall one cycle each.
- A producer becomes invisible 3 edges after it leaves ID, once it has left t_wb. The register file must provide write-before-read in the same cycle for older values.
- Simultaneous matches in several stages resolve by the priority above, never by OR.

## Test plan
- Reset, then ID_VALID = 0 for 3 cycles: PC_LE = 1, IF_ID_LE = 1, ID_EX_NOP = 0, both selects 00, STALL_COUNT = 0.
- ALU `add $5` in ID, then `sub` reading RS = 5 next cycle: MX1_SEL = 01. With an unrelated instruction in between: 10. With two in between: 11. With three in between: 00.
- `lw $8` followed by `add` reading RT = 8:
  - Cycle 1: stall, with PC_LE = 0, IF_ID_LE = 0, ID_EX_NOP = 1, MX2_SEL = 00.
  - Cycle 2: no stall, MX2_SEL = 10.
  - STALL_COUNT = 1.
- `add $0`, then a reader of $0: MX1_SEL = 00 and no stall. `lw $0` then a reader of $0: no stall.
- `add $3`, `or $3`, then a reader of $3 on both RS and RT: MX1_SEL = MX2_SEL = 01 (youngest wins), not 10.
- CNT_W = 2, 5 consecutive load-use pairs: STALL_COUNT runs 1, 2, 3, 3, 3. Reset asserted during a stall cycle: outputs return to the pass-through values the same cycle and the count is 0 after the edge.
